// File: rtl/ristretto_pmp_csr.sv
// PMP CSR file: pmpcfg/pmpaddr registers with lock rules and registered responses.
// One-cycle response latency; accepts a request every cycle with no backpressure.
module ristretto_pmp_csr #(
  parameter int DataWidth  = 32,
  parameter int AddrWidth  = 32,
  parameter int PMPentries = 16
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 csr_req_i,
  input  logic [11:0]                          csr_addr_i,
  input  logic [1:0]                           csr_op_i,
  input  logic [DataWidth-1:0]                 csr_wdata_i,
  input  logic                                 csr_curr_pvm_i,
  output logic                                 csr_rvalid_o,
  output logic [DataWidth-1:0]                 csr_rdata_o,
  output logic                                 csr_illegal_o,
  output logic [DataWidth*(PMPentries/4)-1:0]  pmp_pmpcfg_o,
  output logic [AddrWidth*PMPentries-1:0]      pmp_pmpaddr_o,
  output logic                                 pmp_update_o
);
  localparam int NumCfg = PMPentries / 4;
  localparam logic [1:0] OpWrite = 2'b01;
  localparam logic [1:0] OpSet   = 2'b10;
  localparam logic [1:0] OpClear = 2'b11;

  logic [PMPentries*8-1:0]         cfg_q, cfg_d;
  logic [PMPentries*AddrWidth-1:0] addr_q, addr_d;
  logic [PMPentries-1:0]           l_bit, tor_bit, addr_lock;
  logic [3:0]                      idx;
  logic                            is_cfg, is_addr, illegal, do_write, any_change;
  logic [DataWidth-1:0]            old_val, new_val;
  logic [7:0]                      cfg_byte;

  assign idx      = csr_addr_i[3:0];
  assign is_cfg   = (csr_addr_i[11:4] == 8'h3A) && ({1'b0, idx} < 5'(NumCfg));
  assign is_addr  = (csr_addr_i[11:4] == 8'h3B) && ({1'b0, idx} < 5'(PMPentries));
  assign illegal  = !(is_cfg || is_addr) || !csr_curr_pvm_i;
  // Set/clear with a zero operand cannot change anything and behave as reads.
  assign do_write = csr_req_i && !illegal &&
                    ((csr_op_i == OpWrite) || (csr_op_i[1] && (csr_wdata_i != '0)));

  always_comb begin
    for (int e = 0; e < PMPentries; e++) begin
      l_bit[e]   = cfg_q[e*8+7];
      tor_bit[e] = cfg_q[e*8+7] && (cfg_q[e*8+3 +: 2] == 2'b01);
    end
  end

  // An address is frozen by its own lock or by a locked TOR entry above it.
  assign addr_lock = l_bit | (tor_bit >> 1);

  always_comb begin
    old_val = '0;
    for (int e = 0; e < PMPentries; e++) begin
      if (is_cfg && (e / 4 == int'(idx))) old_val[(e%4)*8 +: 8] = cfg_q[e*8 +: 8];
      if (is_addr && (e == int'(idx))) old_val = DataWidth'(addr_q[e*AddrWidth +: AddrWidth]);
    end
  end

  always_comb begin
    case (csr_op_i)
      OpWrite: new_val = csr_wdata_i;
      OpSet:   new_val = old_val | csr_wdata_i;
      OpClear: new_val = old_val & ~csr_wdata_i;
      default: new_val = old_val;
    endcase
  end

  always_comb begin
    cfg_d    = cfg_q;
    addr_d   = addr_q;
    cfg_byte = '0;
    for (int e = 0; e < PMPentries; e++) begin
      cfg_byte = new_val[(e%4)*8 +: 8] & 8'h9F;
      // R=0/W=1 is reserved, so such a byte leaves the entry untouched.
      if (do_write && is_cfg && (e / 4 == int'(idx)) && !l_bit[e] &&
          (cfg_byte[1:0] != 2'b10))
        cfg_d[e*8 +: 8] = cfg_byte;
      if (do_write && is_addr && (e == int'(idx)) && !addr_lock[e])
        addr_d[e*AddrWidth +: AddrWidth] = AddrWidth'(new_val);
    end
  end

  assign any_change = (cfg_d != cfg_q) || (addr_d != addr_q);

  always_comb begin
    pmp_pmpcfg_o = '0;
    for (int e = 0; e < PMPentries; e++)
      pmp_pmpcfg_o[(e/4)*DataWidth + (e%4)*8 +: 8] = cfg_q[e*8 +: 8];
  end

  assign pmp_pmpaddr_o = addr_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cfg_q         <= '0;
      addr_q        <= '0;
      csr_rvalid_o  <= 1'b0;
      csr_illegal_o <= 1'b0;
      csr_rdata_o   <= '0;
      pmp_update_o  <= 1'b0;
    end else begin
      cfg_q         <= cfg_d;
      addr_q        <= addr_d;
      csr_rvalid_o  <= csr_req_i;
      csr_illegal_o <= csr_req_i && illegal;
      csr_rdata_o   <= (csr_req_i && !illegal) ? old_val : '0;
      pmp_update_o  <= any_change;
    end
  end
endmodule

// File: tb/tb_ristretto_pmp_csr.sv
// Directed and randomized checks of ristretto_pmp_csr against an array-based model.
module tb_ristretto_pmp_csr;
  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         csr_req_i = 1'b0;
  logic [11:0]  csr_addr_i = '0;
  logic [1:0]   csr_op_i = '0;
  logic [31:0]  csr_wdata_i = '0;
  logic         csr_curr_pvm_i = 1'b1;
  logic         csr_rvalid_o;
  logic [31:0]  csr_rdata_o;
  logic         csr_illegal_o;
  logic [127:0] pmp_pmpcfg_o;
  logic [511:0] pmp_pmpaddr_o;
  logic         pmp_update_o;

  ristretto_pmp_csr dut (
    .clk_i(clk_i), .rst_i(rst_i), .csr_req_i(csr_req_i), .csr_addr_i(csr_addr_i),
    .csr_op_i(csr_op_i), .csr_wdata_i(csr_wdata_i), .csr_curr_pvm_i(csr_curr_pvm_i),
    .csr_rvalid_o(csr_rvalid_o), .csr_rdata_o(csr_rdata_o), .csr_illegal_o(csr_illegal_o),
    .pmp_pmpcfg_o(pmp_pmpcfg_o), .pmp_pmpaddr_o(pmp_pmpaddr_o), .pmp_update_o(pmp_update_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  logic [7:0]  cfg_m  [16];
  logic [31:0] addr_m [16];
  logic        exp_vld, exp_ill, exp_upd;
  logic [31:0] exp_rd;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      cfg_m[i]  = 8'h00;
      addr_m[i] = 32'h0;
    end
  endtask

  function automatic logic [127:0] cfg_vec();
    logic [127:0] v = '0;
    for (int e = 0; e < 16; e++) v[e*8 +: 8] = cfg_m[e];
    return v;
  endfunction

  function automatic logic [511:0] addr_vec();
    logic [511:0] v = '0;
    for (int e = 0; e < 16; e++) v[e*32 +: 32] = addr_m[e];
    return v;
  endfunction

  // Reference behaviour: works on whole entries and registers, not on RTL structure.
  task automatic model(input logic req, input logic [1:0] op, input logic [11:0] a,
                       input logic [31:0] wd, input logic pvm);
    int n;
    bit is_cfg, is_addr, locked;
    logic [31:0] old, nv;
    logic [7:0] b;
    exp_vld = req; exp_ill = 0; exp_rd = 0; exp_upd = 0;
    if (!req) return;
    is_cfg  = (a >= 12'h3A0) && (a <= 12'h3A3);
    is_addr = (a >= 12'h3B0) && (a <= 12'h3BF);
    if (!(is_cfg || is_addr) || !pvm) begin
      exp_ill = 1;
      return;
    end
    n = is_cfg ? int'(a) - 'h3A0 : int'(a) - 'h3B0;
    old = is_cfg ? {cfg_m[4*n+3], cfg_m[4*n+2], cfg_m[4*n+1], cfg_m[4*n]} : addr_m[n];
    exp_rd = old;
    case (op)
      2'd1: nv = wd;
      2'd2: nv = old | wd;
      2'd3: nv = old & ~wd;
      default: nv = old;
    endcase
    if (!(op == 2'd1 || (op >= 2'd2 && wd != 0))) return;
    if (is_cfg) begin
      for (int k = 0; k < 4; k++) begin
        b = nv[k*8 +: 8] & 8'h9F;
        if (!cfg_m[4*n+k][7] && !(b[0] == 1'b0 && b[1] == 1'b1)) begin
          if (cfg_m[4*n+k] != b) exp_upd = 1;
          cfg_m[4*n+k] = b;
        end
      end
    end else begin
      locked = cfg_m[n][7];
      if (n < 15) begin
        if (cfg_m[n+1][7] && cfg_m[n+1][4:3] == 2'b01) locked = 1;
      end
      if (!locked) begin
        if (addr_m[n] != nv) exp_upd = 1;
        addr_m[n] = nv;
      end
    end
  endtask

  task automatic check_resp(input string tag);
    chk({tag, ".rvalid"}, 512'(csr_rvalid_o), 512'(exp_vld));
    chk({tag, ".illegal"}, 512'(csr_illegal_o), 512'(exp_ill));
    chk({tag, ".rdata"}, 512'(csr_rdata_o), 512'(exp_rd));
    chk({tag, ".update"}, 512'(pmp_update_o), 512'(exp_upd));
    chk({tag, ".pmpcfg"}, 512'(pmp_pmpcfg_o), 512'(cfg_vec()));
    chk({tag, ".pmpaddr"}, pmp_pmpaddr_o, addr_vec());
  endtask

  task automatic access(input string tag, input logic [1:0] op, input logic [11:0] a,
                        input logic [31:0] wd, input logic pvm);
    csr_req_i = 1; csr_op_i = op; csr_addr_i = a; csr_wdata_i = wd; csr_curr_pvm_i = pvm;
    model(1, op, a, wd, pvm);
    @(posedge clk_i); #1;
    check_resp(tag);
  endtask

  task automatic idle(input string tag);
    csr_req_i = 0; csr_wdata_i = $urandom; csr_op_i = 2'($urandom);
    model(0, 2'd0, 12'h0, 32'h0, 1'b1);
    @(posedge clk_i); #1;
    check_resp(tag);
  endtask

  initial begin
    logic [11:0] a;
    logic [31:0] wd;
    int r;
    model_clear();
    exp_vld = 0; exp_ill = 0; exp_upd = 0; exp_rd = 0;
    @(posedge clk_i); @(posedge clk_i); #1;
    check_resp("reset");
    @(negedge clk_i); rst_i = 0;
    @(posedge clk_i); #1;

    access("w_addr0", 2'd1, 12'h3B0, 32'h2000_0000, 1'b1);
    chk("addr0_const", 512'(pmp_pmpaddr_o[31:0]), 512'(32'h2000_0000));
    chk("addr0_pulse", 512'(pmp_update_o), 512'(1'b1));
    access("r_addr0", 2'd0, 12'h3B0, 32'h0, 1'b1);
    chk("addr0_rdata", 512'(csr_rdata_o), 512'(32'h2000_0000));
    chk("addr0_no_pulse", 512'(pmp_update_o), 512'(1'b0));

    access("w_cfg0_f8f", 2'd1, 12'h3A0, 32'h0000_0F8F, 1'b1);
    chk("cfg0_f8f", 512'(pmp_pmpcfg_o[31:0]), 512'(32'h0000_0F8F));
    access("w_cfg0_0", 2'd1, 12'h3A0, 32'h0, 1'b1);
    chk("cfg0_locked_byte", 512'(pmp_pmpcfg_o[31:0]), 512'(32'h0000_008F));
    access("w_cfg0_88", 2'd1, 12'h3A0, 32'h0000_8800, 1'b1);
    access("w_addr0_lk", 2'd1, 12'h3B0, 32'h1234_5678, 1'b1);
    chk("tor_lock_noupd", 512'(pmp_update_o), 512'(1'b0));
    access("w_addr1_lk", 2'd1, 12'h3B1, 32'h1234_5678, 1'b1);
    chk("l_lock_noill", 512'(csr_illegal_o), 512'(1'b0));
    chk("l_lock_addr", 512'(pmp_pmpaddr_o[63:0]), 512'(64'h0000_0000_2000_0000));
    access("set_addr2", 2'd2, 12'h3B2, 32'h0000_00F0, 1'b1);
    access("clr_addr2", 2'd3, 12'h3B2, 32'h0000_0030, 1'b1);
    access("clr0_addr2", 2'd3, 12'h3B2, 32'h0, 1'b1);

    access("u_read", 2'd0, 12'h3A0, 32'h0, 1'b0);
    chk("u_read_ill", 512'(csr_illegal_o), 512'(1'b1));
    access("bad_addr", 2'd0, 12'h3C5, 32'h0, 1'b1);
    chk("bad_addr_rdata", 512'(csr_rdata_o), 512'(32'h0));
    access("u_write", 2'd1, 12'h3B3, 32'hFFFF_FFFF, 1'b0);

    // Reset lands in the middle of a write request.
    csr_req_i = 1; csr_op_i = 2'd1; csr_addr_i = 12'h3B4; csr_wdata_i = 32'hDEAD_BEEF;
    @(negedge clk_i); rst_i = 1; #1;
    model_clear();
    exp_vld = 0; exp_ill = 0; exp_upd = 0; exp_rd = 0;
    check_resp("mid_reset");
    csr_req_i = 0;
    @(posedge clk_i); @(negedge clk_i); rst_i = 0;
    idle("post_reset");

    access("w_cfg0_62", 2'd1, 12'h3A0, 32'h0000_0062, 1'b1);
    chk("cfg0_62", 512'(pmp_pmpcfg_o[31:0]), 512'(32'h0));

    for (int i = 0; i < 500; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 2)      a = 12'h3A0 + 12'($urandom_range(0, 3));
      else if (r <= 7) a = 12'h3B0 + 12'($urandom_range(0, 15));
      else if (r == 8) a = 12'h3A4 + 12'($urandom_range(0, 11));
      else             a = 12'h3C0 + 12'($urandom_range(0, 63));
      wd = $urandom;
      if (a[11:4] == 8'h3A && $urandom_range(0, 7) != 0) wd = wd & 32'h7F7F_7F7F;
      if ($urandom_range(0, 4) == 0) wd = 32'h0;
      if ($urandom_range(0, 7) == 0) idle("rnd_idle");
      else access("rnd", 2'($urandom), a, wd, 1'($urandom_range(0, 9) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
